// File: rtl/count_checker.sv
// Sequence checker for a wrap-around test counter: tracks the expected
// next count from the counter's own controls and flags any divergence.
module count_checker #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 check_en,
  input  logic                 cnt_clear,
  input  logic                 cnt_enable,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 status_clr,
  output logic                 error,
  output logic                 fail,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] wrap_count,
  output logic [WIDTH-1:0]     expected,
  output logic                 tracking
);

  typedef enum logic {
    IDLE,
    TRACK
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     hist_cnt_q, hist_cnt_d;
  logic                 hist_en_q, hist_en_d;
  logic                 hist_clr_q, hist_clr_d;
  logic [WIDTH-1:0]     exp_q, exp_d;
  logic                 error_q, error_d;
  logic                 fail_q, fail_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0] wrap_cnt_q, wrap_cnt_d;
  logic                 mismatch;
  logic                 wrap_hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      hist_cnt_q <= '0;
      hist_en_q  <= 1'b0;
      hist_clr_q <= 1'b0;
      exp_q      <= '0;
      error_q    <= 1'b0;
      fail_q     <= 1'b0;
      err_cnt_q  <= '0;
      wrap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hist_cnt_q <= hist_cnt_d;
      hist_en_q  <= hist_en_d;
      hist_clr_q <= hist_clr_d;
      exp_q      <= exp_d;
      error_q    <= error_d;
      fail_q     <= fail_d;
      err_cnt_q  <= err_cnt_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hist_cnt_d = count_in;
    hist_en_d  = cnt_enable;
    hist_clr_d = cnt_clear;
    error_d    = 1'b0;
    fail_d     = fail_q;
    err_cnt_d  = err_cnt_q;
    wrap_cnt_d = wrap_cnt_q;
    mismatch   = 1'b0;
    wrap_hit   = 1'b0;

    // exp_q always holds the rule applied to the current history
    if (cnt_clear)       exp_d = '0;
    else if (cnt_enable) exp_d = count_in + WIDTH'(1);
    else                 exp_d = count_in;

    unique case (state_q)
      IDLE: begin
        if (check_en) state_d = TRACK;
      end
      TRACK: begin
        if (!check_en) begin
          state_d = IDLE;
        end else begin
          mismatch = (count_in != exp_q);
          wrap_hit = !mismatch && !hist_clr_q
                     && hist_en_q && (&hist_cnt_q);
        end
      end
      default: state_d = IDLE;
    endcase

    if (mismatch) begin
      error_d = 1'b1;
      fail_d  = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
    end
    if (wrap_hit && wrap_cnt_q != '1)
      wrap_cnt_d = wrap_cnt_q + CNT_WIDTH'(1);

    if (status_clr) begin
      fail_d     = 1'b0;
      err_cnt_d  = '0;
      wrap_cnt_d = '0;
    end
  end

  assign error      = error_q;
  assign fail       = fail_q;
  assign err_count  = err_cnt_q;
  assign wrap_count = wrap_cnt_q;
  assign expected   = exp_q;
  assign tracking   = (state_q == TRACK);

endmodule

// File: tb/tb_count_checker.sv
// Randomized and directed bench for count_checker against a
// cycle-level behavioural model of the counter and checker rules.
module tb_count_checker;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       check_en = 1'b0;
  logic       cnt_clear = 1'b0;
  logic       cnt_enable = 1'b0;
  logic [3:0] count_in = '0;
  logic       status_clr = 1'b0;
  logic       error;
  logic       fail;
  logic [7:0] err_count;
  logic [7:0] wrap_count;
  logic [3:0] expected;
  logic       tracking;

  count_checker #(.WIDTH(4), .CNT_WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .check_en   (check_en),
    .cnt_clear  (cnt_clear),
    .cnt_enable (cnt_enable),
    .count_in   (count_in),
    .status_clr (status_clr),
    .error      (error),
    .fail       (fail),
    .err_count  (err_count),
    .wrap_count (wrap_count),
    .expected   (expected),
    .tracking   (tracking)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // model state
  bit m_trk, m_error, m_fail;
  int m_err, m_wrap, m_exp;
  int p_cnt;
  bit p_en, p_clr;
  int ctr;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rule(input bit clr, input bit en, input int c);
    if (clr) return 0;
    if (en) return (c + 1) % 16;
    return c;
  endfunction

  task automatic model_reset();
    m_trk = 0; m_error = 0; m_fail = 0;
    m_err = 0; m_wrap = 0; m_exp = 0;
    p_cnt = 0; p_en = 0; p_clr = 0;
  endtask

  task automatic model_edge();
    int e;
    e = rule(p_clr, p_en, p_cnt);
    m_error = 0;
    if (!check_en) begin
      m_trk = 0;
    end else if (!m_trk) begin
      m_trk = 1;
    end else if (int'(count_in) != e) begin
      m_error = 1;
      m_fail = 1;
      if (m_err < 255) m_err++;
    end else if (!p_clr && p_en && p_cnt == 15) begin
      if (m_wrap < 255) m_wrap++;
    end
    if (status_clr) begin
      m_fail = 0; m_err = 0; m_wrap = 0;
    end
    p_cnt = int'(count_in);
    p_en = cnt_enable;
    p_clr = cnt_clear;
    m_exp = rule(p_clr, p_en, p_cnt);
  endtask

  task automatic compare_all();
    chk("error", error, m_error);
    chk("fail", fail, m_fail);
    chk("err_count", err_count, m_err);
    chk("wrap_count", wrap_count, m_wrap);
    chk("tracking", tracking, m_trk);
    if (m_trk) chk("expected", expected, m_exp);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  // drive one cycle with an explicit observed value
  task automatic cyc_val(input bit clr, input bit en, input int val);
    cnt_clear = clr;
    cnt_enable = en;
    count_in = 4'(val);
    step();
    ctr = rule(clr, en, val);
  endtask

  task automatic cyc(input bit clr, input bit en, input bit inj);
    int v;
    v = inj ? (ctr + 1 + int'($urandom_range(0, 14))) % 16 : ctr;
    cyc_val(clr, en, v);
  endtask

  initial begin
    model_reset();
    ctr = 0;
    #2;
    chk("rst_error", error, 0);
    chk("rst_fail", fail, 0);
    chk("rst_errcnt", err_count, 0);
    chk("rst_wrapcnt", wrap_count, 0);
    chk("rst_expected", expected, 0);
    chk("rst_tracking", tracking, 0);
    #10 reset = 1'b1;

    // plan 1: clear then 20 increments, one wrap
    check_en = 1'b1;
    repeat (2) cyc(1, 0, 0);
    repeat (20) cyc(0, 1, 0);
    chk("p1_fail", fail, 0);
    chk("p1_errcnt", err_count, 0);
    chk("p1_wrapcnt", wrap_count, 1);

    // plan 2: enable toggling
    repeat (4) begin
      cyc(0, 1, 0);
      cyc(0, 0, 0);
    end
    chk("p2_errcnt", err_count, 0);

    // plan 3: show 7 where 6 is due
    cyc(1, 0, 0);
    while (ctr != 6) cyc(0, 1, 0);
    cyc_val(0, 1, 7);
    chk("p3_pulse", error, 1);
    chk("p3_errcnt", err_count, 1);
    chk("p3_fail", fail, 1);
    chk("p3_ctr", ctr, 8);
    repeat (5) cyc(0, 1, 0);
    chk("p3_resync", err_count, 1);

    // plan 4: clear beats enable at 9
    while (ctr != 9) cyc(0, 1, 0);
    cyc(1, 1, 0);
    cyc(0, 0, 0);
    chk("p4_pass", error, 0);
    while (ctr != 9) cyc(0, 1, 0);
    cyc(1, 1, 0);
    cyc_val(0, 0, 10);
    chk("p4_err", error, 1);
    chk("p4_errcnt", err_count, 2);

    // plan 5: saturate then clear status
    repeat (300) cyc(0, 1, 1);
    chk("p5_sat", err_count, 255);
    status_clr = 1'b1;
    cyc(0, 1, 0);
    status_clr = 1'b0;
    chk("p5_fail", fail, 0);
    chk("p5_errcnt", err_count, 0);

    // plan 6: async reset mid-count
    repeat (3) cyc(0, 1, 0);
    #3 reset = 1'b0;
    model_reset();
    #1;
    chk("p6_error", error, 0);
    chk("p6_fail", fail, 0);
    chk("p6_errcnt", err_count, 0);
    chk("p6_wrapcnt", wrap_count, 0);
    chk("p6_expected", expected, 0);
    chk("p6_tracking", tracking, 0);
    @(negedge clock);
    reset = 1'b1;
    cyc(0, 1, 0);
    chk("p6_track", tracking, 1);
    cyc(0, 1, 0);
    chk("p6_noerr", error, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      check_en = ($urandom_range(0, 19) != 0);
      status_clr = ($urandom_range(0, 29) == 0);
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6,
          $urandom_range(0, 14) == 0);
    end
    status_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
